// File: rtl/instruction_fetch_unit_pkg.sv
// rv_pkg: opcode constants, fetch FSM encoding and field positions (FETCH_ILLEGAL_TRAP_EN adds the TRAP state)
package rv_pkg;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
`ifdef FETCH_ILLEGAL_TRAP_EN
    localparam logic [1:0] ST_TRAP = 2'd3;
    function automatic logic is_supported_op(input logic [6:0] op);
        return op inside {OP_RTYPE, OP_STORE, OP_LUI, OP_ITYPE, OP_LOAD};
    endfunction
`endif
    localparam int OPCODE_LSB = 0;
    localparam int RD_LSB     = 7;
    localparam int FUNCT3_LSB = 12;
    localparam int RS1_LSB    = 15;
    localparam int RS2_LSB    = 20;
    localparam int FUNCT7_LSB = 25;
endpackage

// File: rtl/instruction_fetch_unit_pc_reg.sv
// fetch_pc_reg: program counter with reset load and modulo +4 advance
module fetch_pc_reg #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  i_advance,
    output logic [ADDR_WIDTH-1:0] o_pc
);
    logic [ADDR_WIDTH-1:0] r_pc;
    // load RESET_PC on reset, step by one word on each advance, wrapping naturally
    always_ff @(posedge Clk) begin
        if (!Rst_n) r_pc <= RESET_PC;
        else if (i_advance) r_pc <= r_pc + ADDR_WIDTH'(4);
    end
    assign o_pc = r_pc;
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: multicycle fetch FSM with instruction register (FETCH_ILLEGAL_TRAP_EN enables opcode trap)
module instruction_fetch_unit
    import rv_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  Enable,
    output logic                  IMemReq,
    output logic [ADDR_WIDTH-1:0] IMemAddr,
    input  logic [31:0]           IMemRdata,
    input  logic                  IMemValid,
    input  logic                  InstrReady,
    output logic                  InstrValid,
    output logic [31:0]           Instr,
    output logic [6:0]            Opcode,
    output logic [2:0]            Funct3,
    output logic [6:0]            Funct7,
    output logic [4:0]            Rd,
    output logic [4:0]            Rs1,
    output logic [4:0]            Rs2,
    output logic [ADDR_WIDTH-1:0] PC,
    output logic                  IllegalInstr
);
    logic [1:0]            r_state;
    logic [1:0]            w_next;
    logic [1:0]            w_capture_dst;
    logic [31:0]           r_instr;
    logic [ADDR_WIDTH-1:0] w_pc;
    logic                  w_advance;

    assign w_advance = (r_state == ST_HOLD) && InstrReady;

    fetch_pc_reg #(.ADDR_WIDTH(ADDR_WIDTH), .RESET_PC(RESET_PC)) u_pc (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .i_advance (w_advance),
        .o_pc      (w_pc)
    );

`ifdef FETCH_ILLEGAL_TRAP_EN
    assign w_capture_dst = is_supported_op(IMemRdata[OPCODE_LSB +: 7]) ? ST_HOLD : ST_TRAP;
    assign IllegalInstr  = (r_state == ST_TRAP);
`else
    assign w_capture_dst = ST_HOLD;
    assign IllegalInstr  = 1'b0;
`endif

    // next-state: a request is never abandoned, TRAP (when present) is only left by reset
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: w_next = Enable ? ST_REQ : ST_IDLE;
            ST_REQ:  w_next = IMemValid ? w_capture_dst : ST_REQ;
            ST_HOLD: w_next = InstrReady ? (Enable ? ST_REQ : ST_IDLE) : ST_HOLD;
            default: w_next = r_state;
        endcase
    end

    // state register and instruction capture, memory data is only taken while requesting
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_state <= ST_IDLE;
            r_instr <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_REQ && IMemValid) r_instr <= IMemRdata;
        end
    end

    assign IMemReq    = (r_state == ST_REQ);
    assign IMemAddr   = w_pc;
    assign PC         = w_pc;
    assign InstrValid = (r_state == ST_HOLD);
    assign Instr      = r_instr;
    assign Opcode     = r_instr[OPCODE_LSB +: 7];
    assign Rd         = r_instr[RD_LSB +: 5];
    assign Funct3     = r_instr[FUNCT3_LSB +: 3];
    assign Rs1        = r_instr[RS1_LSB +: 5];
    assign Rs2        = r_instr[RS2_LSB +: 5];
    assign Funct7     = r_instr[FUNCT7_LSB +: 7];
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: randomized scoreboard bench, two instances (RESET_PC 0 and 0xFFFFFFFC)
module tb_instruction_fetch_unit;
    import rv_pkg::*;
    logic        Clk = 0, Rst_n = 0, Enable = 0, IMemValid = 0, InstrReady = 0;
    logic [31:0] IMemRdata = 0;
    logic        req, ivalid, ill, w_req, w_ivalid, w_ill;
    logic [31:0] addr, instr, pc, w_addr, w_instr, w_pc;
    logic [6:0]  opc, f7, w_opc, w_f7;
    logic [2:0]  f3, w_f3;
    logic [4:0]  rd, rs1, rs2, w_rd, w_rs1, w_rs2;
    int total = 0, bad = 0;
    typedef struct { logic [31:0] w; logic [31:0] pc; } exp_t;
    exp_t sb[$];
    exp_t e_m;
    logic [31:0] m_pc = 0, hold_i = 0, hold_pc = 0;
    logic        prev_v = 0;
    logic [6:0]  ops [5] = '{OP_RTYPE, OP_STORE, OP_LUI, OP_ITYPE, OP_LOAD};
    localparam logic [31:0] WOFF = 32'hFFFF_FFFC;

    always #5 Clk = ~Clk;

    instruction_fetch_unit dut (
        .Clk(Clk), .Rst_n(Rst_n), .Enable(Enable), .IMemReq(req), .IMemAddr(addr),
        .IMemRdata(IMemRdata), .IMemValid(IMemValid), .InstrReady(InstrReady),
        .InstrValid(ivalid), .Instr(instr), .Opcode(opc), .Funct3(f3), .Funct7(f7),
        .Rd(rd), .Rs1(rs1), .Rs2(rs2), .PC(pc), .IllegalInstr(ill)
    );

    instruction_fetch_unit #(.RESET_PC(WOFF)) dut_w (
        .Clk(Clk), .Rst_n(Rst_n), .Enable(Enable), .IMemReq(w_req), .IMemAddr(w_addr),
        .IMemRdata(IMemRdata), .IMemValid(IMemValid), .InstrReady(InstrReady),
        .InstrValid(w_ivalid), .Instr(w_instr), .Opcode(w_opc), .Funct3(w_f3), .Funct7(w_f7),
        .Rd(w_rd), .Rs1(w_rs1), .Rs2(w_rs2), .PC(w_pc), .IllegalInstr(w_ill)
    );

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        total++;
        if (a !== x) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", n, a, x, $time);
        end
    endtask

    // monitor: pop on each new presented instruction, verify stability while held
    always @(negedge Clk) begin
        if (ivalid && !prev_v) begin
            if (sb.size() == 0) chk("sb_unexpected", instr, 32'hxxxx_xxxx);
            else begin
                e_m = sb.pop_front();
                chk("instr", instr, e_m.w);
                chk("w_instr", w_instr, e_m.w);
                chk("pc", pc, e_m.pc);
                chk("w_pc", w_pc, e_m.pc + WOFF);
                chk("opcode", 32'(opc), 32'(e_m.w[6:0]));
                chk("rd", 32'(rd), 32'(e_m.w[11:7]));
                chk("funct3", 32'(f3), 32'(e_m.w[14:12]));
                chk("rs1", 32'(rs1), 32'(e_m.w[19:15]));
                chk("rs2", 32'(rs2), 32'(e_m.w[24:20]));
                chk("funct7", 32'(f7), 32'(e_m.w[31:25]));
                hold_i  = e_m.w;
                hold_pc = e_m.pc;
            end
        end else if (ivalid && prev_v) begin
            chk("stall_instr", instr, hold_i);
            chk("stall_pc", pc, hold_pc);
            chk("stall_req", 32'(req), 0);
        end
        chk("w_valid", 32'(w_ivalid), 32'(ivalid));
        prev_v = ivalid;
    end

    task automatic fetch(input logic [31:0] word, input int lat, input logic en_req);
        logic legal;
`ifdef FETCH_ILLEGAL_TRAP_EN
        legal = word[6:0] inside {OP_RTYPE, OP_STORE, OP_LUI, OP_ITYPE, OP_LOAD};
`else
        legal = 1'b1;
`endif
        Enable = 1;
        if (!req) begin @(posedge Clk); #1; end
        chk("req_rise", 32'(req), 1);
        chk("w_req_rise", 32'(w_req), 1);
        Enable = en_req;
        for (int i = 0; i < lat - 1; i++) begin
            InstrReady = 1'($urandom_range(0, 1));
            chk("addr_hold", addr, m_pc);
            chk("w_addr_hold", w_addr, m_pc + WOFF);
            @(posedge Clk); #1;
        end
        chk("addr_last", addr, m_pc);
        IMemRdata = word;
        IMemValid = 1;
        if (legal) sb.push_back('{word, m_pc});
        @(posedge Clk); #1;
        IMemValid = 0;
        InstrReady = 0;
        IMemRdata = $urandom;
        chk("valid_after", 32'(ivalid), 32'(legal));
        chk("illegal", 32'(ill), 32'(!legal));
        chk("req_drop", 32'(req), 0);
    endtask

    task automatic consume(input int stall, input logic en);
        chk("hold_valid", 32'(ivalid), 1);
        for (int i = 0; i < stall; i++) begin
            IMemValid = 1'($urandom_range(0, 1));
            IMemRdata = $urandom;
            @(posedge Clk); #1;
        end
        IMemValid = 0;
        Enable = en;
        InstrReady = 1;
        @(posedge Clk); #1;
        InstrReady = 0;
        m_pc += 4;
        chk("accept_valid", 32'(ivalid), 0);
        chk("next_req", 32'(req), 32'(en));
        chk("next_pc", pc, m_pc);
        chk("w_next_pc", w_pc, m_pc + WOFF);
    endtask

    initial begin
        logic [31:0] w;
        Rst_n = 0; Enable = 1; IMemValid = 1; InstrReady = 1; IMemRdata = 32'h4000_0033;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_req", 32'(req), 0);
        chk("rst_valid", 32'(ivalid), 0);
        chk("rst_pc", pc, 0);
        chk("rst_w_pc", w_pc, WOFF);
        chk("rst_instr", instr, 0);
        chk("rst_ill", 32'(ill), 0);
        Rst_n = 1; Enable = 0; IMemValid = 0; InstrReady = 0;
        @(posedge Clk); #1;
        chk("idle_req", 32'(req), 0);
        fetch(32'h4000_0033, 3, 1);
        chk("sub_opcode", 32'(opc), 32'b0110011);
        chk("sub_funct7", 32'(f7), 32'b0100000);
        chk("sub_funct3", 32'(f3), 0);
        consume(10, 1);
        fetch(32'h0010_0093, 3, 0);
        consume(0, 0);
        @(posedge Clk); #1;
        chk("idle_after_drop", 32'(req), 0);
        chk("idle_pc", pc, 8);
        for (int k = 0; k < 20; k++) begin
            w = $urandom;
            w[6:0] = ops[$urandom_range(0, 4)];
            fetch(w, $urandom_range(1, 4), 1'($urandom_range(0, 1)));
            consume($urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
        Enable = 1;
        @(posedge Clk); #1;
        chk("pre_rst_req", 32'(req), 1);
        Rst_n = 0;
        @(posedge Clk); #1;
        Rst_n = 1; Enable = 0; IMemValid = 1; IMemRdata = 32'h4000_0033;
        m_pc = 0;
        @(posedge Clk); #1;
        IMemValid = 0;
        chk("late_valid", 32'(ivalid), 0);
        chk("late_req", 32'(req), 0);
        chk("late_pc", pc, 0);
        chk("late_instr", instr, 0);
        fetch(32'h0000_006F, 2, 1);
`ifdef FETCH_ILLEGAL_TRAP_EN
        Enable = 1;
        for (int i = 0; i < 5; i++) begin
            @(posedge Clk); #1;
            chk("trap_req", 32'(req), 0);
            chk("trap_ill", 32'(ill), 1);
            chk("trap_pc", pc, m_pc);
            chk("trap_instr", instr, 32'h0000_006F);
        end
`else
        chk("jal_ill", 32'(ill), 0);
        consume(1, 0);
`endif
        @(posedge Clk); #1;
        chk("sb_drain", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Multicycle instruction fetch stage that sits directly upstream of the control unit. It owns the program counter and fetches 32-bit words from instruction memory over a req/valid handshake, then holds each word in an instruction register. From that register it presents the Opcode/Funct3/Funct7 fields to the control unit and the Rd/Rs1/Rs2 fields to the register file, until the execute stage acknowledges consumption.

## Interface
- ADDR_WIDTH, 32, PC and instruction-memory address width
- RESET_PC, 0, PC value loaded on reset; must be 4-byte aligned
- Clk  input  1  sole clock; all state updates on rising edge
- Rst_n  input  1  synchronous, active-low reset, sampled on Clk rising edge
- Enable  input  1  permits new fetches
- IMemReq  output  1  fetch request to instruction memory
- IMemAddr  output  ADDR_WIDTH  fetch address, equals PC
- IMemRdata  input  32  instruction word from memory
- IMemValid  input  1  IMemRdata valid this cycle
- InstrReady  input  1  downstream consumed current instruction
- InstrValid  output  1  Instr and field outputs hold a valid instruction
- Instr  output  32  instruction register
- Opcode  output  7  Instr[6:0]
- Funct3  output  3  Instr[14:12]
- Funct7  output  7  Instr[31:25]
- Rd  output  5  Instr[11:7]
- Rs1  output  5  Instr[19:15]
- Rs2  output  5  Instr[24:20]
- PC  output  ADDR_WIDTH  address of the instruction in Instr
- IllegalInstr  output  1  trap flag; constant 0 when the trap feature is compiled out

## Operation
- FSM states: IDLE, REQ, HOLD, TRAP (TRAP only exists with the trap feature).
- IDLE: IMemReq=0, InstrValid=0. If Enable=1, go to REQ.
- REQ: IMemReq=1 and IMemAddr=PC, both held stable until IMemValid=1. On IMemValid, Instr<=IMemRdata and go to HOLD.
- Deasserting Enable in REQ does not abort an outstanding request.
- HOLD: InstrValid=1; Instr, fields and PC are stable. On InstrReady=1: PC<=PC+4; go to REQ if Enable=1, else IDLE.
- IMemValid outside REQ is ignored. InstrReady outside HOLD is ignored.
- Field outputs are wired slices of the Instr register, so they are glitch-free.
- PC arithmetic is modulo 2^ADDR_WIDTH; 0xFFFF_FFFC+4 wraps to 0x0000_0000. PC[1:0] is always 00.

## Timing
- Reset values: state=IDLE, PC=RESET_PC, Instr=0, IMemReq=0, InstrValid=0, IllegalInstr=0.
- Enable seen high in IDLE at edge N: IMemReq=1 after edge N.
- IMemValid high at edge M: InstrValid=1 after edge M. Minimum fetch-to-valid latency is 2 cycles from IDLE.
- InstrReady at edge K: InstrValid=0 and IMemReq=1 with the new PC after edge K. Back-to-back throughput is one instruction per (memory latency + 1) cycles.
- Rst_n low at any edge overrides all other inputs, including mid-request. A late IMemValid arriving after reset is ignored because the FSM is in IDLE.

## Configuration
- FETCH_ILLEGAL_TRAP_EN defined:
  - When a word is captured in REQ, its opcode is checked against the supported set: 0110011, 0100011, 0110111, 0010011, 0000011.
  - An unsupported opcode sends the FSM to TRAP instead of HOLD. In TRAP: InstrValid=0, IMemReq=0, IllegalInstr=1, and PC and Instr hold the offending instruction.
  - Only reset exits TRAP.
- FETCH_ILLEGAL_TRAP_EN undefined:
  - Every captured word goes to HOLD. IllegalInstr is tied 0.

## Structure
- Shared package rv_pkg holds:
  - opcode constants: OP_RTYPE, OP_STORE, OP_LUI, OP_ITYPE, OP_LOAD
  - fetch FSM state encoding
  - field bit-position constants
- One sub-module: fetch_pc_reg. It holds the PC register, reset load of RESET_PC, and +4 increment with wrap on an advance strobe.

## Test plan
- Reset: hold Rst_n=0 with Enable=1 and IMemValid=1 → PC=0, IMemReq=0, InstrValid=0.
- Single fetch, 3-cycle memory latency, word 0x40000033 (SUB):
  - required: IMemAddr=0 held for 3 cycles; InstrValid rises 1 cycle after IMemValid; Opcode=0110011, Funct7=0100000, Funct3=000.
  - InstrReady then PC=4 and a new request.
- Stall: InstrReady held 0 for 10 cycles → Instr, PC and fields remain constant and IMemReq stays 0.
- Enable drops during REQ: the request completes, the instruction is presented, and after InstrReady the FSM goes to IDLE with PC=4.
- Wrap: RESET_PC=0xFFFFFFFC, one fetch plus InstrReady → PC=0x00000000.
- With FETCH_ILLEGAL_TRAP_EN: word 0x0000006F (JAL) → IllegalInstr=1, InstrValid=0, PC unchanged, no further IMemReq until reset. Without the macro, the same word is presented normally.
